// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared funct3 op codes, FSM state encoding and defaults for the
// iterative multiply/divide unit.
package muldiv_pkg;
  localparam int MD_XLEN = 64;
  localparam logic [2:0] MD_OP_MUL    = 3'd0;
  localparam logic [2:0] MD_OP_MULH   = 3'd1;
  localparam logic [2:0] MD_OP_MULHSU = 3'd2;
  localparam logic [2:0] MD_OP_MULHU  = 3'd3;
  localparam logic [2:0] MD_OP_DIV    = 3'd4;
  localparam logic [2:0] MD_OP_DIVU   = 3'd5;
  localparam logic [2:0] MD_OP_REM    = 3'd6;
  localparam logic [2:0] MD_OP_REMU   = 3'd7;
  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_FIX,
    MD_DONE
  } md_state_e;
  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: start/busy/done request interface between EX-stage control and the
// multiply/divide unit.
interface muldiv_if #(
  parameter int XLEN = 64
);
  logic            start;
  logic [2:0]      op;
  logic            word;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] res;
  modport master (
    output start, op, word, a, b, flush,
    input  busy, done, res
  );
  modport slave (
    input  start, op, word, a, b, flush,
    output busy, done, res
  );
endinterface

// File: rtl/muldiv_prep.sv
// muldiv_prep: combinational operand conditioning -- word selection, sign/zero
// extension, magnitudes, result sign flags and divide special-case detection.
module muldiv_prep
  import muldiv_pkg::*;
#(
  parameter int XLEN     = MD_XLEN,
  parameter int WORD_OPS = 1
) (
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            word_eff,
  output logic            is_div,
  output logic [XLEN-1:0] mag_a,
  output logic [XLEN-1:0] mag_b,
  output logic            neg_q,
  output logic            neg_r,
  output logic            special,
  output logic [XLEN-1:0] spec_res
);
  localparam bit WO = WORD_OPS != 0 && XLEN == 64;
  logic            sgn_a, sgn_b, sx, na, nb, is_rem, div0, ovf;
  logic [XLEN-1:0] ea, eb, min_v, raw;
  always_comb begin
    word_eff = WO && word && !(op inside {MD_OP_MULH, MD_OP_MULHSU, MD_OP_MULHU});
    is_div   = op inside {MD_OP_DIV, MD_OP_DIVU, MD_OP_REM, MD_OP_REMU};
    is_rem   = op inside {MD_OP_REM, MD_OP_REMU};
    sgn_a    = op inside {MD_OP_MULH, MD_OP_MULHSU, MD_OP_DIV, MD_OP_REM};
    sgn_b    = op inside {MD_OP_MULH, MD_OP_DIV, MD_OP_REM};
    sx       = op inside {MD_OP_MUL, MD_OP_DIV, MD_OP_REM};
    ea       = !word_eff ? a : sx ? XLEN'(sext32(a[31:0])) : XLEN'(a[31:0]);
    eb       = !word_eff ? b : sx ? XLEN'(sext32(b[31:0])) : XLEN'(b[31:0]);
    na       = sgn_a && ea[XLEN-1];
    nb       = sgn_b && eb[XLEN-1];
    mag_a    = na ? -ea : ea;
    mag_b    = nb ? -eb : eb;
    neg_q    = (na ^ nb) && (eb != '0);
    neg_r    = na;
    // W operands are already sign-extended, so the most-negative test happens at full width
    min_v    = word_eff ? ~XLEN'(32'h7FFF_FFFF) : {1'b1, {(XLEN-1){1'b0}}};
    div0     = is_div && eb == '0;
    ovf      = is_div && sgn_b && ea == min_v && eb == '1;
    special  = div0 || ovf;
    raw      = div0 ? (is_rem ? ea : '1) : (is_rem ? '0 : ea);
    spec_res = word_eff ? XLEN'(sext32(raw[31:0])) : raw;
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV M-extension multiply/divide with start/busy/done handshake.
// Define MULDIV_FAST_MUL_EN to replace the shift-add multiply with a registered native multiply.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN     = MD_XLEN,
  parameter int WORD_OPS = 1
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  md_state_e         state, state_n;
  logic [2:0]        op_q;
  logic              word_q, neg_q_q, neg_r_q;
  logic [2*XLEN-1:0] acc, x, p_s, fast_p;
  logic [XLEN-1:0]   y, res, q_s, r_s, full, fix_res, rem_n;
  logic [CW-1:0]     cnt;
  logic [XLEN:0]     t;
  logic              word_eff, is_div, neg_q, neg_r, special, accept, ge, div_q;
  logic [XLEN-1:0]   mag_a, mag_b, spec_res;

  muldiv_prep #(
    .XLEN    (XLEN),
    .WORD_OPS(WORD_OPS)
  ) u_prep (
    .op      (bus.op),
    .word    (bus.word),
    .a       (bus.a),
    .b       (bus.b),
    .word_eff(word_eff),
    .is_div  (is_div),
    .mag_a   (mag_a),
    .mag_b   (mag_b),
    .neg_q   (neg_q),
    .neg_r   (neg_r),
    .special (special),
    .spec_res(spec_res)
  );

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
  assign fast_p = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`else
  localparam bit FAST_MUL = 1'b0;
  assign fast_p = '0;
`endif

  assign bus.busy = state != MD_IDLE;
  assign bus.done = state == MD_DONE;
  assign bus.res  = res;

  always_comb begin
    div_q   = op_q inside {MD_OP_DIV, MD_OP_DIVU, MD_OP_REM, MD_OP_REMU};
    accept  = state == MD_IDLE && bus.start && !bus.flush;
    // restoring divide: acc holds {remainder, dividend/quotient} and shifts left one bit per step
    t       = acc[2*XLEN-1:XLEN-1];
    ge      = t >= {1'b0, x[XLEN-1:0]};
    rem_n   = ge ? XLEN'(t - {1'b0, x[XLEN-1:0]}) : t[XLEN-1:0];
    p_s     = neg_q_q ? -acc : acc;
    q_s     = neg_q_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    r_s     = neg_r_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    full    = !div_q ? (op_q == MD_OP_MUL ? p_s[XLEN-1:0] : p_s[2*XLEN-1:XLEN])
            : (op_q inside {MD_OP_REM, MD_OP_REMU}) ? r_s : q_s;
    fix_res = word_q ? XLEN'(sext32(full[31:0])) : full;
    state_n = state == MD_IDLE ? (!accept ? MD_IDLE : special ? MD_DONE
                                  : (FAST_MUL && !is_div) ? MD_FIX : MD_CALC)
            : (bus.flush || state == MD_DONE) ? MD_IDLE
            : state == MD_FIX ? MD_DONE
            : cnt == '0 ? MD_FIX : MD_CALC;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MD_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      word_q  <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      acc     <= '0;
      x       <= '0;
      y       <= '0;
      cnt     <= '0;
      res     <= '0;
    end else if (accept) begin
      op_q    <= bus.op;
      word_q  <= word_eff;
      neg_q_q <= neg_q;
      neg_r_q <= neg_r;
      cnt     <= word_eff ? CW'(31) : CW'(XLEN - 1);
      x       <= {{XLEN{1'b0}}, is_div ? mag_b : mag_a};
      y       <= mag_b;
      // W divides pre-align the 32-bit dividend to the top so 32 steps consume it
      acc     <= is_div ? {{XLEN{1'b0}}, mag_a << (word_eff ? 32 : 0)} : fast_p;
      if (special) res <= spec_res;
    end else if (state == MD_CALC) begin
      cnt <= cnt - CW'(1);
      acc <= div_q ? {rem_n, acc[XLEN-2:0], ge} : acc + (y[0] ? x : '0);
      x   <= div_q ? x : x << 1;
      y   <= y >> 1;
    end else if (state == MD_FIX && !bus.flush) begin
      res <= fix_res;
    end
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV64M/RV32M multiply/divide engine for the EX stage, parametrised in XLEN.
- Replaces single-cycle ALU arithmetic for M-extension ops with a multi-cycle start/busy/done handshake.
- Pipeline control holds ID/EX and freezes EX/MEM while busy is high.
- Supports 64-bit and word (W-suffix) ops, RISC-V divide-by-zero/overflow semantics and flush abort.

Parameters:
XLEN, 64, datapath width; 32 or 64 only.
WORD_OPS, 1, enables W-op handling; forced to 0 when XLEN==32.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  request; sampled only in IDLE.
op  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
word  in  1  W-variant (32-bit operate, sign-extend result).
a  in  XLEN  rs1 operand.
b  in  XLEN  rs2 operand.
flush  in  1  abort current operation.
busy  out  1  high from the cycle after an accepted start until done.
done  out  1  one-cycle pulse; res valid.
res  out  XLEN  result; held stable until next accepted start.

Behaviour:
- Reset (async): state IDLE; busy=0, done=0, res=0; all internal registers cleared. Reset mid-operation aborts immediately with no done.
- States:
  - IDLE: start & !flush latches op/word/conditioned operands. Goes to DONE if a special case applies, else to CALC.
  - CALC: one radix-2 step per cycle. Shift-add multiply or restoring divide on operand magnitudes. N = 32 if word, else XLEN. After N steps goes to FIX.
  - FIX: applies sign correction, selects high/low half or quotient/remainder, sign-extends W results from bit 31. Goes to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Latency, with the start edge as cycle 0:
  - Iterative ops: done high in cycle N+2 (64-bit: 66, W: 34).
  - Special cases: done high in cycle 1.
- busy is high in every cycle of CALC, FIX and DONE, and drops with done.
- start while busy is ignored and not queued.
- Operand conditioning:
  - MULH and DIV/REM treat both operands as signed. MULHSU treats a as signed, b as unsigned.
  - W ops use a[31:0] and b[31:0], sign-extended for DIVW/REMW/MULW and zero-extended for DIVUW/REMUW.
  - word with op 1..3 is treated as word=0.
- Special cases (divide, divisor==0 after width selection): quotient = all ones (W: sign-extended 32'hFFFF_FFFF); remainder = dividend.
- Signed overflow (dividend == most-negative, divisor == -1): quotient = dividend; remainder = 0.
- Sign rules: remainder takes the sign of the dividend; quotient is negative iff operand signs differ and divisor != 0.
- flush: synchronous; from any non-IDLE state returns to IDLE on the next edge with no done, and res keeps its previous value. flush together with start in IDLE: start is dropped.
- Width: the product is held as a 2*XLEN accumulator, and MUL returns its low XLEN bits. No arithmetic exception outputs.

Optional Feature:
MULDIV_FAST_MUL_EN:
- Defined: multiplies bypass CALC and use a registered native multiply. IDLE goes to FIX and done is high in cycle 2 for all MUL* ops. Divides are unchanged.
- Undefined: all multiplies are iterative as above. Results are bit-identical in both builds.

Decomposition:
- Shared package/header (common.vh): MD_OP_* funct3 constants, the 2-bit state encoding (MD_IDLE, MD_CALC, MD_FIX, MD_DONE) and MD_XLEN default.
- One natural sub-module: muldiv_prep. It is combinational and does word selection, sign/zero extension, magnitude/absolute value, result-sign flags and special-case detection. It is instantiated once in muldiv_unit.

Test Plan:
1. XLEN=64: MUL a=7, b=-3 -> res=64'hFFFF_FFFF_FFFF_FFEB; done in cycle 66 only; busy high in cycles 1..66.
2. MULHU a=b=64'hFFFF_FFFF_FFFF_FFFF -> 64'hFFFF_FFFF_FFFF_FFFE. MULHSU a=-1, b=2 -> 64'hFFFF_FFFF_FFFF_FFFF.
3. DIV a=5, b=0 -> 64'hFFFF_FFFF_FFFF_FFFF, and REM a=5, b=0 -> 5; both with done in cycle 1. DIV a=64'h8000_0000_0000_0000, b=-1 -> a, and REM with the same operands -> 0.
4. DIVW a=64'h0000_0001_8000_0000, b=2 -> 64'hFFFF_FFFF_C000_0000 with done in cycle 34. REMUW a=32'hFFFF_FFFF, b=10 -> 5. REM a=-7, b=2 -> -1.
5. Handshake: a second start at cycle 10 of a DIV is ignored, with a single done and the original result. flush at cycle 20 -> busy=0 at cycle 21, no done, res unchanged. Back-to-back start the cycle after done is accepted.
6. rst asserted asynchronously mid-CALC -> busy/done/res read 0 before the next clock edge. With MULDIV_FAST_MUL_EN, repeat case 1 -> same res, done in cycle 2.
